vid_mem_slave: RTL and testbench
================================

# vid_mem_slave

Bus-side memory responder for the display subsystem: the target end of the request/response protocol the display controller drives as an initiator. It accepts single- and multi-beat read requests (rreq) and write requests (wreq followed by dp beats) from a selected master, services them from an internal word-addressed 32-bit memory, and returns rres data beats or a wres completion, holding each response until the fabric acknowledges it. It sits on the slave side of the interconnect and serves both frame-buffer and cursor-bitmap fetches.

## Interface
- DEPTH, 4096: memory words (power of 2).
- RD_LAT, 1: cycles from request capture to first rres beat valid (1..4).
- MASTER_ID, 0: value driven on reqtar with every response.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- selin  input  1  this slave selected; cmdin/lenin/addrdatain valid.
- cmdin  input  3  command: noreq=0, dp=1, rreq=2, rres=3, wreq=4, wres=5, re=6, we=7.
- lenin  input  2  burst length minus one (0 = 1 beat, 3 = 4 beats).
- addrdatain  input  64  byte address on rreq/wreq; write data [31:0] on dp.
- reqout  output  2  1 = response beat pending, 0 = idle.
- lenout  output  2  echo of captured length.
- addrdataout  output  64  rres: {32'b0, data}; wres: {32'b0, 32'b0}.
- cmdout  output  3  rres or wres during a pending beat, else noreq.
- reqtar  output  4  MASTER_ID while reqout=1, else 0.
- ackin  input  1  fabric accepted the current beat.

## Operation
- Word index = addr[log2(DEPTH)+1:2]; addr[1:0] and bits above ignored (modulo wrap). Burst beats at index+k, wrapping mod DEPTH.
- States: IDLE, RD_LAT, RD_SEND, WR_DATA, WR_RESP.
- IDLE: selin & rreq -> capture index, len; RD_LAT. selin & wreq -> capture index, len; WR_DATA. All other commands ignored.
- RD_LAT: count RD_LAT-1 cycles (0 extra when RD_LAT=1), then RD_SEND.
- RD_SEND: drive reqout=1, cmdout=rres, addrdataout={32'b0, mem[idx]}, lenout=len. Hold stable until ackin=1 sampled. On ack: last beat -> clear outputs, IDLE; else idx+1, next beat driven on the following cycle.
- WR_DATA: each selin & dp writes addrdatain[31:0] to mem[idx], idx+1. After len+1 dp beats -> WR_RESP. Non-dp commands ignored.
- WR_RESP: reqout=1, cmdout=wres, addrdataout=0 until ackin; then clear, IDLE.
- Requests arriving outside IDLE are dropped (no queue); masters must not issue a request before the previous response completes.
- ackin while reqout=0 is ignored.

## Timing
- Reset values: reqout=0, lenout=0, addrdataout=0, cmdout=0 (noreq), reqtar=0; state IDLE; memory contents unaffected by reset.
- Reset mid-burst: outputs clear immediately (asynchronously), partial write beats already stored remain, and the transaction is abandoned.
- Read: rreq sampled at edge T -> first beat valid after edge T+RD_LAT. Minimum 1 cycle per beat (ackin held high -> one beat per clock).
- Write: dp at edge T writes memory at T; a read of that word issued afterward returns the new data. wres valid after the edge following the last dp.
- All outputs registered; no combinational path from inputs to outputs.
- ackin and the final dp in the same cycle: no conflict (distinct states).

## Structure
- Shared package (vid_bus_pkg): command enum (noreq..we), reqout encodings, bus widths (ADDR_DATA_W=64, CMD_W=3, LEN_W=2, TAR_W=4). The display controller imports the same package.
- One sub-module: vid_mem_ram, a single-port 32-bit synchronous RAM (DEPTH words, one read or write per cycle), with the FSM in the top module.

## Test plan
- Write word 0x1020_3040 via wreq addr 0x10 and one dp -> wres with reqtar=MASTER_ID, then rreq 0x10 -> single rres with addrdataout=0x0000_0000_1020_3040.
- 4-beat write (lenin=3) at addr 0x0 with data 1, 2, 3, 4 -> 4-beat read with ackin high every cycle returns 1, 2, 3, 4 on consecutive cycles, lenout=3, then reqout=0.
- Read with ackin held low for 5 cycles -> beat 0 held stable all 5 cycles, and beat 1 appears only the cycle after ackin rises.
- Burst read at word index DEPTH-2, lenin=3 -> data from indices DEPTH-2, DEPTH-1, 0, 1.
- rreq issued during RD_SEND -> ignored, and the current burst completes unchanged.
- Reset asserted during beat 2 of 4 -> all outputs 0 immediately, state IDLE, and the next rreq is serviced normally.

Source files
------------

// File: rtl/vid_bus_pkg.sv
// -----------------------------------------------------------------------------
// vid_bus_pkg
// Shared definitions for the display-subsystem request/response bus. It is
// imported by both the display controller (initiator) and the memory slaves
// (targets), so that command codes and field widths stay in one place.
//   ADDR_DATA_W : width of the multiplexed address/data field
//   CMD_W       : width of the command field
//   LEN_W       : width of the burst-length field (beats minus one)
//   TAR_W       : width of the response target-id field
//   DATA_W      : width of one memory data word
// -----------------------------------------------------------------------------
package vid_bus_pkg;

   localparam int ADDR_DATA_W = 64;
   localparam int CMD_W       = 3;
   localparam int LEN_W       = 2;
   localparam int TAR_W       = 4;
   localparam int DATA_W      = 32;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOREQ = 3'd0,
      CMD_DP    = 3'd1,
      CMD_RREQ  = 3'd2,
      CMD_RRES  = 3'd3,
      CMD_WREQ  = 3'd4,
      CMD_WRES  = 3'd5,
      CMD_RE    = 3'd6,
      CMD_WE    = 3'd7
   } cmd_e;

   // Encoding of the reqout field
   typedef enum logic [1:0] {
      REQ_IDLE = 2'd0,
      REQ_PEND = 2'd1
   } reqout_e;

endpackage

// File: rtl/vid_mem_ram.sv
// -----------------------------------------------------------------------------
// vid_mem_ram
// Single-port synchronous RAM, one read or one write per clock. On a write
// cycle the read register keeps its previous value. Contents are not reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : registered read data (value at i_addr from the previous edge)
// -----------------------------------------------------------------------------
module vid_mem_ram #(
   parameter int DEPTH  = 4096,
   parameter int DATA_W = 32
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [DATA_W-1:0]        i_wdata,
   output logic [DATA_W-1:0]        o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end else begin
         r_q <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/vid_mem_slave.sv
// -----------------------------------------------------------------------------
// vid_mem_slave
// Memory target on the display bus. It accepts single/multi-beat reads (rreq)
// and writes (wreq + dp beats), serves them from an internal word-addressed
// RAM, and holds each rres/wres beat until the fabric acknowledges it.
//   clk         : clock
//   reset       : asynchronous active-high reset
//   selin       : slave selected, request fields valid
//   cmdin       : incoming command
//   lenin       : burst length minus one
//   addrdatain  : byte address (rreq/wreq) or write data in [31:0] (dp)
//   reqout      : 1 while a response beat is pending
//   lenout      : captured burst length during a response
//   addrdataout : {32'b0, data} for rres, zero for wres
//   cmdout      : rres / wres while pending, else noreq
//   reqtar      : MASTER_ID while pending, else 0
//   ackin       : fabric accepted the current beat
// -----------------------------------------------------------------------------
module vid_mem_slave
   import vid_bus_pkg::*;
#(
   parameter int DEPTH     = 4096,
   parameter int RD_LAT    = 1,
   parameter int MASTER_ID = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   selin,
   input  logic [CMD_W-1:0]       cmdin,
   input  logic [LEN_W-1:0]       lenin,
   input  logic [ADDR_DATA_W-1:0] addrdatain,
   output logic [1:0]             reqout,
   output logic [LEN_W-1:0]       lenout,
   output logic [ADDR_DATA_W-1:0] addrdataout,
   output logic [CMD_W-1:0]       cmdout,
   output logic [TAR_W-1:0]       reqtar,
   input  logic                   ackin
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_LAT,
      ST_RD_SEND,
      ST_WR_DATA,
      ST_WR_RESP
   } state_e;

   state_e            r_state, w_state_nxt;
   logic [AW-1:0]     r_idx, w_idx_nxt;
   logic [LEN_W-1:0]  r_len, w_len_nxt;
   logic [LEN_W-1:0]  r_beat, w_beat_nxt;
   logic [1:0]        r_lat, w_lat_nxt;

   logic              w_ram_we;
   logic [AW-1:0]     w_ram_addr;
   logic [DATA_W-1:0] w_ram_q;
   logic [AW-1:0]     w_req_idx;
   logic              w_pend;

   assign w_req_idx = addrdatain[AW+1:2];

   vid_mem_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_ram (
      .i_clk   (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (addrdatain[DATA_W-1:0]),
      .o_rdata (w_ram_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_lat   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_len   <= w_len_nxt;
         r_beat  <= w_beat_nxt;
         r_lat   <= w_lat_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_len_nxt   = r_len;
      w_beat_nxt  = r_beat;
      w_lat_nxt   = r_lat;
      w_ram_we    = 1'b0;
      w_ram_addr  = r_idx;
      case (r_state)
         ST_IDLE: begin
            if (selin && (cmdin == CMD_RREQ)) begin
               w_idx_nxt   = w_req_idx;
               w_len_nxt   = lenin;
               w_beat_nxt  = '0;
               w_lat_nxt   = '0;
               w_state_nxt = ST_RD_LAT;
            end else if (selin && (cmdin == CMD_WREQ)) begin
               w_idx_nxt   = w_req_idx;
               w_len_nxt   = lenin;
               w_beat_nxt  = '0;
               w_state_nxt = ST_WR_DATA;
            end
         end
         ST_RD_LAT: begin
            if (r_lat == LAT_LAST) begin
               w_state_nxt = ST_RD_SEND;
            end else begin
               w_lat_nxt = r_lat + 2'd1;
            end
         end
         ST_RD_SEND: begin
            if (ackin) begin
               if (r_beat == r_len) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  // Present the next index to the RAM now so the following
                  // beat is ready right after this acknowledging edge.
                  w_idx_nxt  = r_idx + 1'b1;
                  w_beat_nxt = r_beat + 1'b1;
                  w_ram_addr = r_idx + 1'b1;
               end
            end
         end
         ST_WR_DATA: begin
            if (selin && (cmdin == CMD_DP)) begin
               w_ram_we  = 1'b1;
               w_idx_nxt = r_idx + 1'b1;
               if (r_beat == r_len) begin
                  w_state_nxt = ST_WR_RESP;
               end else begin
                  w_beat_nxt = r_beat + 1'b1;
               end
            end
         end
         ST_WR_RESP: begin
            if (ackin) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decode only registered state and the RAM output register, so
   // they clear as soon as reset forces the state back to IDLE.
   always_comb begin
      w_pend      = (r_state == ST_RD_SEND) || (r_state == ST_WR_RESP);
      reqout      = w_pend ? REQ_PEND : REQ_IDLE;
      lenout      = w_pend ? r_len : '0;
      reqtar      = w_pend ? TAR_W'(MASTER_ID) : '0;
      cmdout      = CMD_NOREQ;
      addrdataout = '0;
      if (r_state == ST_RD_SEND) begin
         cmdout      = CMD_RRES;
         addrdataout = {32'b0, w_ram_q};
      end else if (r_state == ST_WR_RESP) begin
         cmdout = CMD_WRES;
      end
   end

endmodule

// File: tb/tb_vid_mem_slave.sv
module tb_vid_mem_slave;
   import vid_bus_pkg::*;

   logic        clk;
   logic        reset;
   logic        selin;
   logic [2:0]  cmdin;
   logic [1:0]  lenin;
   logic [63:0] addrdatain;
   logic [1:0]  reqout;
   logic [1:0]  lenout;
   logic [63:0] addrdataout;
   logic [2:0]  cmdout;
   logic [3:0]  reqtar;
   logic        ackin;

   int n_pass;
   int n_total;

   vid_mem_slave #(
      .DEPTH     (4096),
      .RD_LAT    (1),
      .MASTER_ID (5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .selin       (selin),
      .cmdin       (cmdin),
      .lenin       (lenin),
      .addrdatain  (addrdatain),
      .reqout      (reqout),
      .lenout      (lenout),
      .addrdataout (addrdataout),
      .cmdout      (cmdout),
      .reqtar      (reqtar),
      .ackin       (ackin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive(input logic [2:0] c, input logic [1:0] l, input logic [63:0] ad);
      selin      = 1'b1;
      cmdin      = c;
      lenin      = l;
      addrdatain = ad;
      @(negedge clk);
      selin      = 1'b0;
      cmdin      = 3'd0;
      lenin      = 2'd0;
      addrdatain = '0;
   endtask

   initial begin
      n_pass     = 0;
      n_total    = 0;
      reset      = 1'b1;
      selin      = 1'b0;
      cmdin      = 3'd0;
      lenin      = 2'd0;
      addrdatain = '0;
      ackin      = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_reqout", 64'(reqout), 64'd0);
      chk("rst_cmdout", 64'(cmdout), 64'd0);
      chk("rst_lenout", 64'(lenout), 64'd0);
      chk("rst_data", addrdataout, 64'd0);
      chk("rst_reqtar", 64'(reqtar), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // single write then single read at 0x10
      drive(3'd4, 2'd0, 64'h10);
      chk("wr1_nopend", 64'(reqout), 64'd0);
      drive(3'd1, 2'd0, 64'h1020_3040);
      chk("wres_reqout", 64'(reqout), 64'd1);
      chk("wres_cmdout", 64'(cmdout), 64'd5);
      chk("wres_reqtar", 64'(reqtar), 64'd5);
      chk("wres_data", addrdataout, 64'd0);
      ackin = 1'b1;
      @(negedge clk);
      ackin = 1'b0;
      chk("wres_done", 64'(reqout), 64'd0);
      chk("wres_done_cmd", 64'(cmdout), 64'd0);
      drive(3'd2, 2'd0, 64'h10);
      chk("rd1_latency", 64'(reqout), 64'd0);
      @(negedge clk);
      chk("rd1_reqout", 64'(reqout), 64'd1);
      chk("rd1_cmdout", 64'(cmdout), 64'd3);
      chk("rd1_reqtar", 64'(reqtar), 64'd5);
      chk("rd1_data", addrdataout, 64'h0000_0000_1020_3040);
      ackin = 1'b1;
      @(negedge clk);
      ackin = 1'b0;
      chk("rd1_done", 64'(reqout), 64'd0);
      chk("rd1_done_data", addrdataout, 64'd0);
      chk("rd1_done_tar", 64'(reqtar), 64'd0);

      // 4-beat write at 0 then 4-beat read, ack every cycle
      drive(3'd4, 2'd3, 64'h0);
      drive(3'd1, 2'd0, 64'd1);
      drive(3'd1, 2'd0, 64'd2);
      drive(3'd1, 2'd0, 64'd3);
      chk("wr4_noearly", 64'(reqout), 64'd0);
      drive(3'd1, 2'd0, 64'd4);
      chk("wr4_cmdout", 64'(cmdout), 64'd5);
      chk("wr4_lenout", 64'(lenout), 64'd3);
      ackin = 1'b1;
      @(negedge clk);
      ackin = 1'b0;
      drive(3'd2, 2'd3, 64'h0);
      @(negedge clk);
      ackin = 1'b1;
      chk("rd4_b0", addrdataout, 64'd1);
      chk("rd4_len", 64'(lenout), 64'd3);
      @(negedge clk);
      chk("rd4_b1", addrdataout, 64'd2);
      chk("rd4_b1_req", 64'(reqout), 64'd1);
      @(negedge clk);
      chk("rd4_b2", addrdataout, 64'd3);
      @(negedge clk);
      chk("rd4_b3", addrdataout, 64'd4);
      chk("rd4_b3_cmd", 64'(cmdout), 64'd3);
      @(negedge clk);
      ackin = 1'b0;
      chk("rd4_end", 64'(reqout), 64'd0);
      chk("rd4_end_len", 64'(lenout), 64'd0);

      // backpressure: beat 0 held for 5 cycles with ack low
      drive(3'd2, 2'd3, 64'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", addrdataout, 64'd1);
      end
      ackin = 1'b1;
      @(negedge clk);
      chk("bp_b1", addrdataout, 64'd2);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      ackin = 1'b0;
      chk("bp_end", 64'(reqout), 64'd0);

      // wrap: write indices 4094, 4095 (upper and low address bits ignored)
      drive(3'd4, 2'd1, 64'hFFFF_0000_0000_3FFB);
      drive(3'd1, 2'd0, 64'hAAAA_AAAA_AAAA_0001);
      drive(3'd1, 2'd0, 64'h0000_0000_BBBB_0002);
      ackin = 1'b1;
      @(negedge clk);
      ackin = 1'b0;
      drive(3'd2, 2'd3, 64'h3FF8);
      @(negedge clk);
      ackin = 1'b1;
      chk("wrap_b0", addrdataout, 64'h0000_0000_AAAA_0001);
      @(negedge clk);
      chk("wrap_b1", addrdataout, 64'h0000_0000_BBBB_0002);
      @(negedge clk);
      chk("wrap_b2", addrdataout, 64'd1);
      @(negedge clk);
      chk("wrap_b3", addrdataout, 64'd2);
      @(negedge clk);
      ackin = 1'b0;
      chk("wrap_end", 64'(reqout), 64'd0);

      // rreq during RD_SEND is dropped
      drive(3'd2, 2'd1, 64'h0);
      @(negedge clk);
      chk("drop_b0", addrdataout, 64'd1);
      drive(3'd2, 2'd3, 64'h3FF8);
      chk("drop_b0_hold", addrdataout, 64'd1);
      chk("drop_len", 64'(lenout), 64'd1);
      ackin = 1'b1;
      @(negedge clk);
      chk("drop_b1", addrdataout, 64'd2);
      @(negedge clk);
      ackin = 1'b0;
      chk("drop_end", 64'(reqout), 64'd0);
      @(negedge clk);
      chk("drop_stay_idle", 64'(reqout), 64'd0);
      @(negedge clk);
      chk("drop_stay_idle2", 64'(reqout), 64'd0);

      // reset during beat 2 of 4
      drive(3'd2, 2'd3, 64'h0);
      @(negedge clk);
      ackin = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_b2", addrdataout, 64'd3);
      #2 reset = 1'b1;
      #1;
      chk("rstm_reqout", 64'(reqout), 64'd0);
      chk("rstm_data", addrdataout, 64'd0);
      chk("rstm_cmdout", 64'(cmdout), 64'd0);
      chk("rstm_lenout", 64'(lenout), 64'd0);
      chk("rstm_reqtar", 64'(reqtar), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      ackin = 1'b0;
      @(negedge clk);
      chk("rstm_idle", 64'(reqout), 64'd0);
      drive(3'd2, 2'd0, 64'h10);
      @(negedge clk);
      chk("post_rst_data", addrdataout, 64'h0000_0000_1020_3040);
      chk("post_rst_req", 64'(reqout), 64'd1);
      chk("post_rst_len", 64'(lenout), 64'd0);
      ackin = 1'b1;
      @(negedge clk);
      ackin = 1'b0;
      chk("post_rst_end", 64'(reqout), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
